// File: rtl/ltc2333_read_impl.sv
`timescale 1ns/1ps
// LTC2333 dual-chip serial readout: delays strobes to the SDO sample point, deserialises
// 24-bit words per lane, and queues formatted words into a FWFT AXI-Stream FIFO.
// Optional span checking with err_cnt is enabled by defining LTC2333_READ_SPAN_CHECK_EN.
module ltc2333_read_impl #(
  parameter int unsigned SAMPLE_DELAY = 2,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        frame_start,
  input  logic        bit_strobe,
  input  logic [3:0]  n_chan_frame,
  input  logic [2:0]  range,
  input  logic [1:0]  sdo,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        overflow,
  input  logic        overflow_clr
`ifdef LTC2333_READ_SPAN_CHECK_EN
  , output logic [15:0] err_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {PUSH_NONE, PUSH_CHIP0, PUSH_CHIP1} push_t;

  state_t state, state_nxt;
  push_t  push_ph;

  logic [SAMPLE_DELAY-1:0] start_pipe, strobe_pipe;
  logic        dstart, dstrobe, start_ok_c, word_done_c, frame_done_c;
  logic [4:0]  bit_cnt;
  logic [3:0]  word_cnt, n_lat;
  logic [23:0] sr0, sr1, pend0, pend1;
  logic        pend_last;

  assign dstart       = start_pipe[SAMPLE_DELAY-1];
  assign dstrobe      = strobe_pipe[SAMPLE_DELAY-1];
  assign start_ok_c   = dstart && (n_chan_frame != 4'd0);
  assign word_done_c  = (state == SHIFT) && dstrobe && (bit_cnt == 5'd23);
  assign frame_done_c = (word_cnt + 4'd1) == n_lat;

  // Align strobe/start with the cycle in which the matching SDO bit is valid
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      start_pipe  <= '0;
      strobe_pipe <= '0;
    end else begin
      start_pipe  <= SAMPLE_DELAY'({start_pipe, frame_start});
      strobe_pipe <= SAMPLE_DELAY'({strobe_pipe, bit_strobe});
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok_c) state_nxt = SHIFT;
      SHIFT:   if (!start_ok_c && word_done_c && frame_done_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Deserialiser and two-cycle push sequencer for the completed word pair
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bit_cnt   <= '0;
      word_cnt  <= '0;
      n_lat     <= '0;
      sr0       <= '0;
      sr1       <= '0;
      pend0     <= '0;
      pend1     <= '0;
      pend_last <= 1'b0;
      push_ph   <= PUSH_NONE;
    end else begin
      case (push_ph)
        PUSH_CHIP0: push_ph <= PUSH_CHIP1;
        PUSH_CHIP1: push_ph <= PUSH_NONE;
        default:    push_ph <= PUSH_NONE;
      endcase
      if (start_ok_c) begin
        bit_cnt  <= dstrobe ? 5'd1 : 5'd0;
        word_cnt <= '0;
        n_lat    <= n_chan_frame;
        if (dstrobe) begin
          sr0 <= {sr0[22:0], sdo[0]};
          sr1 <= {sr1[22:0], sdo[1]};
        end
      end else if (state == SHIFT && dstrobe) begin
        sr0 <= {sr0[22:0], sdo[0]};
        sr1 <= {sr1[22:0], sdo[1]};
        if (word_done_c) begin
          bit_cnt   <= '0;
          word_cnt  <= word_cnt + 4'd1;
          pend0     <= {sr0[22:0], sdo[0]};
          pend1     <= {sr1[22:0], sdo[1]};
          pend_last <= frame_done_c;
          push_ph   <= PUSH_CHIP0;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

  logic        push_c, push_chip_c, push_ok_c, pop_c, full_c, err_bit_c;
  logic [23:0] push_sr_c;
  logic [32:0] push_word_c, head_c;
  logic [32:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_nxt_c, rd_nxt_c;

  assign push_c      = push_ph != PUSH_NONE;
  assign push_chip_c = push_ph == PUSH_CHIP1;
  assign push_sr_c   = push_chip_c ? pend1 : pend0;

`ifdef LTC2333_READ_SPAN_CHECK_EN
  assign err_bit_c = push_sr_c[2:0] != range;
`else
  assign err_bit_c = 1'b0;
`endif

  assign push_word_c = {push_chip_c && pend_last, err_bit_c, 6'd0, push_chip_c,
                        push_sr_c[5:3], push_sr_c[2:0], push_sr_c[23:6]};

  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_c     = m_axis_tvalid && m_axis_tready;
  assign push_ok_c = push_c && (!full_c || pop_c);
  assign wr_nxt_c  = wr_ptr + PW'(push_ok_c);
  assign rd_nxt_c  = rd_ptr + PW'(pop_c);

  assign head_c       = mem[rd_ptr[AW-1:0]];
  assign m_axis_tdata = head_c[31:0];
  assign m_axis_tlast = head_c[32];

  // FWFT FIFO; storage is reset so the head reads as zero after reset
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (push_ok_c) mem[wr_ptr[AW-1:0]] <= push_word_c;
      wr_ptr        <= wr_nxt_c;
      rd_ptr        <= rd_nxt_c;
      m_axis_tvalid <= wr_nxt_c != rd_nxt_c;
      if (overflow_clr)              overflow <= 1'b0;
      else if (push_c && !push_ok_c) overflow <= 1'b1;
    end
  end

`ifdef LTC2333_READ_SPAN_CHECK_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) err_cnt <= '0;
    else if (push_ok_c && err_bit_c && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ltc2333_read_impl.sv
`timescale 1ns/1ps
// Directed bench for ltc2333_read_impl: table of single-word frames plus corner sequences.
module tb_ltc2333_read_impl;
  localparam int unsigned D = 2;

  logic        clk = 1'b0;
  logic        aresetn, frame_start, bit_strobe, m_axis_tready, overflow_clr;
  logic [3:0]  n_chan_frame;
  logic [2:0]  range;
  logic [1:0]  sdo;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, overflow;
`ifdef LTC2333_READ_SPAN_CHECK_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  ltc2333_read_impl #(.SAMPLE_DELAY(D), .FIFO_DEPTH(8)) dut (
    .clk(clk), .aresetn(aresetn), .frame_start(frame_start), .bit_strobe(bit_strobe),
    .n_chan_frame(n_chan_frame), .range(range), .sdo(sdo),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .overflow(overflow), .overflow_clr(overflow_clr)
`ifdef LTC2333_READ_SPAN_CHECK_EN
    , .err_cnt(err_cnt)
`endif
  );

  logic        q_start[$];
  logic        q_strb[$];
  logic [1:0]  q_sdo[$];
  logic [32:0] got[$];
  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk)
    if (aresetn && m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tdata});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected-word adjustment for the span-check build
  function automatic logic [31:0] adj(input logic [31:0] w, input logic [2:0] rng);
`ifdef LTC2333_READ_SPAN_CHECK_EN
    if (w[20:18] != rng) w[31] = 1'b1;
`endif
    return w;
  endfunction

  function automatic logic [23:0] mk(input int data, input int ch, input int sp);
    return {18'(data), 3'(ch), 3'(sp)};
  endfunction

  function automatic logic [31:0] fmt(input logic chip, input logic [23:0] s);
    return {7'd0, chip, s[5:3], s[2:0], s[23:6]};
  endfunction

  function automatic void add_bits(input logic start, input logic [23:0] w0, input logic [23:0] w1,
                                   input int nb);
    for (int b = 23; b > 23 - nb; b--) begin
      q_start.push_back(start && b == 23);
      q_strb.push_back(1'b1);
      q_sdo.push_back({w1[b], w0[b]});
    end
  endfunction

  // Drive strobes; each SDO bit is presented D cycles after its strobe
  task automatic play();
    int n;
    n = q_strb.size();
    for (int i = 0; i < n + D; i++) begin
      frame_start = (i < n) ? q_start[i] : 1'b0;
      bit_strobe  = (i < n) ? q_strb[i] : 1'b0;
      sdo         = (i >= D && i - D < n) ? q_sdo[i-D] : 2'b00;
      @(posedge clk); #1;
    end
    frame_start = 1'b0; bit_strobe = 1'b0; sdo = 2'b00;
    q_start.delete(); q_strb.delete(); q_sdo.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [23:0] s0;
    logic [23:0] s1;
    logic [2:0]  rng;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t vt[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold;
    int nlast;
    vt[0] = '{24'hABCDE5, 24'h00001C, 3'd5, 32'h0096AF37, 32'h01700000};
    vt[1] = '{24'hFFFFFF, 24'h000000, 3'd7, 32'h00FFFFFF, 32'h01000000};
    vt[2] = '{24'h000040, 24'h800000, 3'd0, 32'h00000001, 32'h01020000};
    vt[3] = '{24'h12345A, 24'h00002B, 3'd2, 32'h006848D1, 32'h01AC0000};

    aresetn = 1'b0; frame_start = 1'b0; bit_strobe = 1'b0; sdo = 2'b00;
    n_chan_frame = 4'd1; range = 3'd5; m_axis_tready = 1'b0; overflow_clr = 1'b0;
    cycles(3);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_overflow", overflow, 0);
`ifdef LTC2333_READ_SPAN_CHECK_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    aresetn = 1'b1;
    cycles(2);

    // Single-word frames from the table
    m_axis_tready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      range = vt[v].rng; n_chan_frame = 4'd1; got.delete();
      add_bits(1'b1, vt[v].s0, vt[v].s1, 24);
      play();
      cycles(8);
      chk($sformatf("vec%0d_count", v), got.size(), 2);
      if (got.size() >= 2) begin
        chk($sformatf("vec%0d_chip0", v), got[0], {1'b0, adj(vt[v].e0, vt[v].rng)});
        chk($sformatf("vec%0d_chip1", v), got[1], {1'b1, adj(vt[v].e1, vt[v].rng)});
      end
    end

    // Eight-word frame, then a stray word without frame_start
    range = 3'd5; n_chan_frame = 4'd8; got.delete();
    for (int j = 0; j < 8; j++)
      add_bits(j == 0, mk(j * 3 + 1, j, 5), mk(j + 100, 7 - j, 5), 24);
    play();
    add_bits(1'b0, 24'hFFFFFF, 24'hFFFFFF, 24);
    play();
    cycles(8);
    chk("frame8_count", got.size(), 16);
    nlast = 0;
    for (int i = 0; i < got.size(); i++) nlast += int'(got[i][32]);
    chk("frame8_nlast", nlast, 1);
    if (got.size() == 16) begin
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("frame8_w%0d_c0", j), got[2*j], {1'b0, fmt(1'b0, mk(j * 3 + 1, j, 5))});
        chk($sformatf("frame8_w%0d_c1", j), got[2*j+1],
            {j == 7, fmt(1'b1, mk(j + 100, 7 - j, 5))});
      end
    end

    // frame_start with zero words is ignored
    n_chan_frame = 4'd0; got.delete();
    add_bits(1'b1, 24'h123456, 24'h654321, 24);
    play();
    cycles(8);
    chk("zero_frame_count", got.size(), 0);

    // Restart after 10 bits discards the partial word
    n_chan_frame = 4'd1; got.delete();
    add_bits(1'b1, 24'hFFFFFF, 24'hFFFFFF, 10);
    add_bits(1'b1, vt[0].s0, vt[0].s1, 24);
    play();
    cycles(8);
    chk("restart_count", got.size(), 2);
    if (got.size() >= 1) chk("restart_w0", got[0], {1'b0, adj(32'h0096AF37, 3'd5)});

    // Overflow: three 4-word frames with tready low
    m_axis_tready = 1'b0; n_chan_frame = 4'd4; got.delete();
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 4; j++)
        add_bits(j == 0, mk(f * 16 + j, j, 5), mk(f * 16 + j + 8, j + 4, 5), 24);
    play();
    cycles(6);
    chk("ovf_tvalid", m_axis_tvalid, 1);
    chk("ovf_flag", overflow, 1);
    hold = m_axis_tdata;
    chk("ovf_head", hold, fmt(1'b0, mk(0, 0, 5)));
    cycles(3);
    chk("ovf_hold", m_axis_tdata, hold);
    overflow_clr = 1'b1;
    cycles(1);
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    m_axis_tready = 1'b1;
    cycles(14);
    chk("drain_count", got.size(), 8);
    chk("drain_empty", m_axis_tvalid, 0);
    if (got.size() == 8) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("drain_w%0d_c0", j), got[2*j], {1'b0, fmt(1'b0, mk(j, j, 5))});
        chk($sformatf("drain_w%0d_c1", j), got[2*j+1], {j == 3, fmt(1'b1, mk(j + 8, j + 4, 5))});
      end
    end

    // Reset mid-word with words queued
    m_axis_tready = 1'b0; n_chan_frame = 4'd2; got.delete();
    add_bits(1'b1, mk(1, 1, 5), mk(2, 2, 5), 24);
    add_bits(1'b0, mk(3, 3, 5), mk(4, 4, 5), 24);
    add_bits(1'b1, 24'hAAAAAA, 24'h555555, 12);
    play();
    chk("prerst_tvalid", m_axis_tvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tdata", m_axis_tdata, 0);
    cycles(2);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    cycles(4);
    chk("postrst_empty", got.size(), 0);

    // New frame after reset, span mismatch on chip 0
    range = 3'd3; n_chan_frame = 4'd1;
    add_bits(1'b1, 24'h00002D, 24'h00001B, 24);
    play();
    cycles(8);
    chk("span_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("span_c0", got[0], {1'b0, adj(32'h00B40000, 3'd3)});
      chk("span_c1", got[1], {1'b1, adj(32'h016C0000, 3'd3)});
    end
`ifdef LTC2333_READ_SPAN_CHECK_EN
    chk("span_err_cnt", err_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
